// File: rtl/l1_tag_wait_model.sv
// Direct-mapped tag/valid model that produces Mealy stall timing for one L1 port.
// Data lives elsewhere; this block only tracks tags, refill latency and hit/miss statistics.
module l1_tag_wait_model #(
    parameter int ADDR_W         = 32,
    parameter int NUM_SETS       = 64,
    parameter int LINE_BYTES     = 16,
    parameter int MISS_LATENCY   = 4,
    parameter int WRITE_ALLOCATE = 1,
    parameter int CNT_W          = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic              flush,
    output logic              wait_data,
    output logic              hit,
    output logic              busy,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int OFFSET_W = $clog2(LINE_BYTES);
    localparam int INDEX_W  = $clog2(NUM_SETS);
    localparam int TAG_W    = ADDR_W - OFFSET_W - INDEX_W;
    localparam int LAT_W    = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY) : 1;

    typedef enum logic {IDLE, FILL} state_t;

    state_t             state_reg, state_next;
    logic [LAT_W-1:0]   cnt_reg, cnt_next;
    logic [INDEX_W-1:0] fill_index_reg, fill_index_next;
    logic [TAG_W-1:0]   fill_tag_reg, fill_tag_next;
    logic               replay_reg, replay_next;
    logic               flush_pending_reg, flush_pending_next;
    logic [CNT_W-1:0]   hit_count_reg, hit_count_next;
    logic [CNT_W-1:0]   miss_count_reg, miss_count_next;
    logic [NUM_SETS-1:0] valid_reg, valid_next;
    logic [TAG_W-1:0]   tag_mem [NUM_SETS];

    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               hit_int;
    logic               wait_int;
    logic               complete;
    logic               count_as_miss;
    logic               fill_done;
    logic               flush_all;
    logic               unused_offset;

    assign index         = addr[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign tag           = addr[ADDR_W-1:OFFSET_W+INDEX_W];
    assign unused_offset = ^addr[OFFSET_W-1:0];
    assign hit_int       = valid_reg[index] && (tag_mem[index] == tag);

    assign hit        = hit_int;
    // Gate with rst_n so the stall drops the moment reset asserts, even with req held.
    assign wait_data  = wait_int & rst_n;
    assign busy       = (state_reg == FILL);
    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;

    always_comb begin
        state_next         = state_reg;
        cnt_next           = cnt_reg;
        fill_index_next    = fill_index_reg;
        fill_tag_next      = fill_tag_reg;
        replay_next        = replay_reg;
        flush_pending_next = flush_pending_reg;
        hit_count_next     = hit_count_reg;
        miss_count_next    = miss_count_reg;
        wait_int           = 1'b0;
        complete           = 1'b0;
        count_as_miss      = replay_reg;
        fill_done          = 1'b0;
        flush_all          = 1'b0;

        case (state_reg)
            IDLE: begin
                flush_all = flush;
                if (!req) begin
                    replay_next = 1'b0;
                end else if (hit_int) begin
                    complete = 1'b1;
                end else if (!we || (WRITE_ALLOCATE != 0)) begin
                    wait_int        = 1'b1;
                    fill_index_next = index;
                    fill_tag_next   = tag;
                    cnt_next        = LAT_W'(MISS_LATENCY - 1);
                    state_next      = FILL;
                end else begin
                    // Write-around miss: completes immediately without allocating.
                    complete      = 1'b1;
                    count_as_miss = 1'b1;
                end
            end
            FILL: begin
                wait_int = 1'b1;
                if (flush) begin
                    flush_pending_next = 1'b1;
                end
                if (cnt_reg == '0) begin
                    fill_done          = 1'b1;
                    flush_all          = flush | flush_pending_reg;
                    flush_pending_next = 1'b0;
                    replay_next        = 1'b1;
                    state_next         = IDLE;
                end else begin
                    cnt_next = cnt_reg - LAT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        if (complete) begin
            replay_next = 1'b0;
            if (count_as_miss) begin
                if (miss_count_reg != '1) miss_count_next = miss_count_reg + CNT_W'(1);
            end else begin
                if (hit_count_reg != '1) hit_count_next = hit_count_reg + CNT_W'(1);
            end
        end
    end

    // Per-line valid update: a completing fill beats a concurrent or pending flush.
    generate
        for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_valid
            always_comb begin
                valid_next[gi] = valid_reg[gi];
                if (fill_done && (fill_index_reg == INDEX_W'(gi))) begin
                    valid_next[gi] = 1'b1;
                end else if (flush_all) begin
                    valid_next[gi] = 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            cnt_reg           <= '0;
            fill_index_reg    <= '0;
            fill_tag_reg      <= '0;
            replay_reg        <= 1'b0;
            flush_pending_reg <= 1'b0;
            hit_count_reg     <= '0;
            miss_count_reg    <= '0;
            valid_reg         <= '0;
        end else begin
            state_reg         <= state_next;
            cnt_reg           <= cnt_next;
            fill_index_reg    <= fill_index_next;
            fill_tag_reg      <= fill_tag_next;
            replay_reg        <= replay_next;
            flush_pending_reg <= flush_pending_next;
            hit_count_reg     <= hit_count_next;
            miss_count_reg    <= miss_count_next;
            valid_reg         <= valid_next;
        end
    end

    // Tag storage needs no reset: entries are only trusted once their valid bit is set.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_mem[fill_index_reg] <= fill_tag_reg;
        end
    end

endmodule

// File: tb/tb_l1_tag_wait_model.sv
// Directed bench for l1_tag_wait_model: a write-allocate and a write-around instance share stimulus.
module tb_l1_tag_wait_model;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic        flush = 1'b0;

    logic        wait_a, hit_a, busy_a;
    logic [31:0] hits_a, misses_a;
    logic        wait_b, hit_b, busy_b;
    logic [31:0] hits_b, misses_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    l1_tag_wait_model #(.WRITE_ALLOCATE(1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .flush(flush),
        .wait_data(wait_a), .hit(hit_a), .busy(busy_a),
        .hit_count(hits_a), .miss_count(misses_a)
    );

    l1_tag_wait_model #(.WRITE_ALLOCATE(0)) dut_wa (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .flush(flush),
        .wait_data(wait_b), .hit(hit_b), .busy(busy_b),
        .hit_count(hits_b), .miss_count(misses_b)
    );

    task automatic apply_reset();
        req   = 1'b0;
        flush = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Holds one access until the observed instance drops wait; flush is raised on cycle flush_at.
    task automatic do_access(input logic [31:0] a, input logic w, input bit sel,
                             input int flush_at, output int waits, output int busys);
        bit done = 0;
        req = 1'b1; we = w; addr = a;
        waits = 0; busys = 0;
        for (int c = 0; c < 30; c++) begin
            flush = (c == flush_at);
            @(negedge clk);
            if (sel ? wait_b : wait_a) waits++;
            if (sel ? busy_b : busy_a) busys++;
            if (!(sel ? wait_b : wait_a)) done = 1;
            @(posedge clk);
            #1;
            if (done) break;
        end
        req = 1'b0; flush = 1'b0;
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL access_timeout addr=%h: wait still high after 30 cycles, required low", a);
        end
        $display("access inst=%0d addr=%h we=%0d waits=%0d busy=%0d", sel, a, w, waits, busys);
    endtask

    task automatic test_reset();
        apply_reset();
        addr = 32'h100;
        @(negedge clk);
        n_vec++; if (wait_a !== 1'b0) begin n_err++; $display("FAIL reset_wait got=%b exp=0", wait_a); end
        n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
        n_vec++; if (hit_a !== 1'b0) begin n_err++; $display("FAIL reset_hit got=%b exp=0", hit_a); end
        n_vec++; if (hits_a !== 0 || misses_a !== 0) begin
            n_err++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", hits_a, misses_a);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_cold_and_spatial();
        int w, b;
        apply_reset();
        do_access(32'h100, 1'b0, 0, -1, w, b);
        n_vec++; if (w !== 5) begin n_err++; $display("FAIL cold_waits got=%0d exp=5", w); end
        n_vec++; if (b !== 4) begin n_err++; $display("FAIL cold_busy got=%0d exp=4", b); end
        n_vec++; if (misses_a !== 1 || hits_a !== 0) begin
            n_err++; $display("FAIL cold_counts got=%0d/%0d exp=0/1", hits_a, misses_a);
        end
        do_access(32'h104, 1'b0, 0, -1, w, b);
        n_vec++; if (w !== 0) begin n_err++; $display("FAIL spatial1_waits got=%0d exp=0", w); end
        do_access(32'h10C, 1'b0, 0, -1, w, b);
        n_vec++; if (w !== 0) begin n_err++; $display("FAIL spatial2_waits got=%0d exp=0", w); end
        n_vec++; if (hits_a !== 2 || misses_a !== 1) begin
            n_err++; $display("FAIL spatial_counts got=%0d/%0d exp=2/1", hits_a, misses_a);
        end
    endtask

    task automatic test_conflict();
        int w, b;
        logic [31:0] seq [4] = '{32'h100, 32'h500, 32'h100, 32'h500};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            do_access(seq[i], 1'b0, 0, -1, w, b);
            n_vec++; if (w !== 5) begin n_err++; $display("FAIL conflict%0d_waits got=%0d exp=5", i, w); end
        end
        n_vec++; if (misses_a !== 4 || hits_a !== 0) begin
            n_err++; $display("FAIL conflict_counts got=%0d/%0d exp=0/4", hits_a, misses_a);
        end
    endtask

    task automatic test_write_policy();
        int w, b;
        apply_reset();
        do_access(32'h600, 1'b1, 0, -1, w, b);
        n_vec++; if (w !== 5) begin n_err++; $display("FAIL wralloc_waits got=%0d exp=5", w); end
        apply_reset();
        do_access(32'h200, 1'b1, 1, -1, w, b);
        n_vec++; if (w !== 0) begin n_err++; $display("FAIL wraround_waits got=%0d exp=0", w); end
        n_vec++; if (misses_b !== 1 || hits_b !== 0) begin
            n_err++; $display("FAIL wraround_counts got=%0d/%0d exp=0/1", hits_b, misses_b);
        end
        do_access(32'h200, 1'b0, 1, -1, w, b);
        n_vec++; if (w !== 5) begin n_err++; $display("FAIL wraround_read_waits got=%0d exp=5", w); end
        do_access(32'h208, 1'b1, 1, -1, w, b);
        n_vec++; if (w !== 0) begin n_err++; $display("FAIL wraround_hit_waits got=%0d exp=0", w); end
        n_vec++; if (misses_b !== 2 || hits_b !== 1) begin
            n_err++; $display("FAIL wraround_final got=%0d/%0d exp=1/2", hits_b, misses_b);
        end
    endtask

    task automatic test_flush();
        int w, b;
        apply_reset();
        do_access(32'h300, 1'b0, 0, -1, w, b);
        do_access(32'h100, 1'b0, 0, 2, w, b);
        n_vec++; if (w !== 5) begin n_err++; $display("FAIL flushfill_waits got=%0d exp=5", w); end
        do_access(32'h100, 1'b0, 0, -1, w, b);
        n_vec++; if (w !== 0) begin n_err++; $display("FAIL flushfill_keep got=%0d exp=0", w); end
        do_access(32'h300, 1'b0, 0, -1, w, b);
        n_vec++; if (w !== 5) begin n_err++; $display("FAIL flushfill_drop got=%0d exp=5", w); end
        // Flush in IDLE: same-cycle lookup sees pre-flush contents, the next one misses.
        do_access(32'h300, 1'b0, 0, 0, w, b);
        n_vec++; if (w !== 0) begin n_err++; $display("FAIL idleflush_same got=%0d exp=0", w); end
        do_access(32'h300, 1'b0, 0, -1, w, b);
        n_vec++; if (w !== 5) begin n_err++; $display("FAIL idleflush_after got=%0d exp=5", w); end
        n_vec++; if (hits_a !== 2 || misses_a !== 4) begin
            n_err++; $display("FAIL flush_counts got=%0d/%0d exp=2/4", hits_a, misses_a);
        end
    endtask

    task automatic test_reset_mid_fill();
        int w, b;
        apply_reset();
        do_access(32'h300, 1'b0, 0, -1, w, b);
        do_access(32'h300, 1'b0, 0, -1, w, b);
        req = 1'b1; we = 1'b0; addr = 32'h100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL midfill_busy got=%b exp=1", busy_a); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (wait_a !== 1'b0 || busy_a !== 1'b0) begin
            n_err++; $display("FAIL midfill_rst_outs wait=%b busy=%b exp=0/0", wait_a, busy_a);
        end
        n_vec++; if (hits_a !== 0 || misses_a !== 0) begin
            n_err++; $display("FAIL midfill_rst_counts got=%0d/%0d exp=0/0", hits_a, misses_a);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        do_access(32'h100, 1'b0, 0, -1, w, b);
        n_vec++; if (w !== 5) begin n_err++; $display("FAIL midfill_retry got=%0d exp=5", w); end
    endtask

    initial begin
        test_reset();
        test_cold_and_spatial();
        test_conflict();
        test_write_policy();
        test_flush();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
